gf2m_sqrt_iter: RTL and testbench



---
 rtl/gf2m_sqrt_iter.sv | 143 ++++++++++++++
 tb/tb_gf2m_sqrt_iter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_sqrt_iter.sv
// gf2m_sqrt_iter: iterative GF(2^M) square root, c = a^(2^(M-1)) mod f.
// Ports: clk, rst_n; in_valid/in_ready/a; out_valid/out_ready/c; chk_err.
// Option: GF2M_SQRT_CHECK_EN adds a squaring self-check that drives chk_err.
module gf2m_sqrt_iter #(
  parameter int           M = 163,
  parameter logic [M-1:0] F = 163'hC9,
  parameter int           S = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] c,
  output logic         chk_err
);

  localparam int RW = $clog2(M);
  localparam logic [RW-1:0] LAST = RW'(M - 1);
  localparam logic [RW-1:0] SW = RW'(S);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Spread bits to even positions, then fold the top M-1 bits back
  // down from the highest, using x^M = F.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] x);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) t[2*i] = x[i];
    for (int i = 2*M-2; i >= M; i--) begin
      if (t[i]) begin
        t[i] = 1'b0;
        t[i-M +: M] = t[i-M +: M] ^ F;
      end
    end
    return t[M-1:0];
  endfunction

  state_t        state_q, state_d;
  logic [M-1:0]  acc_q, acc_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          in_ready_q, out_valid_q;

  logic [RW-1:0] step;
  logic [M-1:0]  acc_next;
  logic [M-1:0]  sq_t;

  // Squarer chain; the tap is the stage that matches this cycle's
  // step, which is short on the final pass when S does not divide M-1.
  always_comb begin
    step     = (rem_q < SW) ? rem_q : SW;
    acc_next = acc_q;
    sq_t     = acc_q;
    for (int k = 1; k <= S; k++) begin
      sq_t = gf_sq(sq_t);
      if (step == RW'(k)) acc_next = sq_t;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = a;
          rem_d   = LAST;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_next;
        rem_d = rem_q - step;
        if (rem_d == '0) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c         = acc_q;

`ifdef GF2M_SQRT_CHECK_EN
  logic [M-1:0] orig_q, orig_d;
  logic         chk_q, chk_d;

  // Squaring the final root must give back the operand.
  always_comb begin
    orig_d = orig_q;
    chk_d  = chk_q;
    if (state_q == IDLE && in_valid) begin
      orig_d = a;
      chk_d  = 1'b0;
    end
    if (state_q == RUN && state_d == HOLD)
      chk_d = (gf_sq(acc_next) != orig_q);
    if (state_q == HOLD && out_ready)
      chk_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig_q <= '0;
      chk_q  <= 1'b0;
    end else begin
      orig_q <= orig_d;
      chk_q  <= chk_d;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_gf2m_sqrt_iter.sv
// tb_gf2m_sqrt_iter: directed bench for gf2m_sqrt_iter.
// Instances: M=5 S=1, M=5 S=3, M=163 S=7.
module tb_gf2m_sqrt_iter;

  localparam logic [162:0] FB = 163'hC9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic v1 = 0, r1, ov1, or1 = 0, e1;
  logic [4:0] a1 = '0, c1;
  logic v3 = 0, r3, ov3, or3 = 0, e3;
  logic [4:0] a3 = '0, c3;
  logic vb = 0, rb, ovb, orb = 0, eb;
  logic [162:0] ab = '0, cb;

  int tests = 0;
  int fails = 0;

  gf2m_sqrt_iter #(.M(5), .F(5'h05), .S(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .a(a1),
    .out_valid(ov1), .out_ready(or1), .c(c1), .chk_err(e1));

  gf2m_sqrt_iter #(.M(5), .F(5'h05), .S(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .a(a3),
    .out_valid(ov3), .out_ready(or3), .c(c3), .chk_err(e3));

  gf2m_sqrt_iter #(.M(163), .F(FB), .S(7)) ub (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rb), .a(ab),
    .out_valid(ovb), .out_ready(orb), .c(cb), .chk_err(eb));

  // Reference: shift-and-add multiply with interleaved reduction.
  function automatic logic [162:0] mulmod(input logic [162:0] x,
      input logic [162:0] y, input int m, input logic [162:0] f);
    logic [162:0] r, mask;
    logic top;
    mask = {163{1'b1}} >> (163 - m);
    r = '0;
    for (int i = m - 1; i >= 0; i--) begin
      top = r[m-1];
      r = (r << 1) & mask;
      if (top) r = r ^ f;
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  function automatic logic rdy(input int w);
    case (w)
      1: return r1;
      3: return r3;
      default: return rb;
    endcase
  endfunction

  function automatic logic ov(input int w);
    case (w)
      1: return ov1;
      3: return ov3;
      default: return ovb;
    endcase
  endfunction

  function automatic logic [162:0] cc(input int w);
    case (w)
      1: return 163'(c1);
      3: return 163'(c3);
      default: return cb;
    endcase
  endfunction

  function automatic logic ee(input int w);
    case (w)
      1: return e1;
      3: return e3;
      default: return eb;
    endcase
  endfunction

  task automatic drive(input int w, input logic v, input logic [162:0] x);
    case (w)
      1: begin v1 = v; a1 = x[4:0]; end
      3: begin v3 = v; a3 = x[4:0]; end
      default: begin vb = v; ab = x; end
    endcase
  endtask

  task automatic ack(input int w, input logic v);
    case (w)
      1: or1 = v;
      3: or3 = v;
      default: orb = v;
    endcase
  endtask

  // One full transaction; lat counts edges from accept to out_valid,
  // the accept edge included.
  task automatic op(input int w, input logic [162:0] x,
      output logic [162:0] y, output int lat, output logic err);
    int n;
    n = 0;
    drive(w, 1'b1, x);
    while (!rdy(w) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    drive(w, 1'b0, x);
    lat = 1;
    while (!ov(w) && lat < 500) begin
      @(posedge clk); #1; lat++;
    end
    if (!ov(w)) begin
      tests++; fails++;
      $display("FAIL op_timeout inst=%0d out_valid=0 required 1", w);
    end
    y = cc(w);
    err = ee(w);
    ack(w, 1'b1);
    @(posedge clk); #1;
    ack(w, 1'b0);
  endtask

  task automatic test_reset;
    int ws[3] = '{1, 3, 163};
    @(posedge clk); #1;
    foreach (ws[i]) begin
      tests++;
      if (rdy(ws[i]) !== 1'b1) begin
        fails++;
        $display("FAIL reset_in_ready inst=%0d got %b want 1", ws[i], rdy(ws[i]));
      end
      tests++;
      if (ov(ws[i]) !== 1'b0) begin
        fails++;
        $display("FAIL reset_out_valid inst=%0d got %b want 0", ws[i], ov(ws[i]));
      end
      tests++;
      if (cc(ws[i]) !== '0) begin
        fails++;
        $display("FAIL reset_c inst=%0d got %h want 0", ws[i], cc(ws[i]));
      end
      tests++;
      if (ee(ws[i]) !== 1'b0) begin
        fails++;
        $display("FAIL reset_chk_err inst=%0d got %b want 0", ws[i], ee(ws[i]));
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    logic [162:0] av[4] = '{163'h02, 163'h00, 163'h01, 163'h02};
    logic [162:0] xv[4] = '{163'h1B, 163'h00, 163'h01, 163'h1B};
    int wv[4] = '{1, 1, 1, 3};
    int lv[4] = '{5, 5, 5, 3};
    logic [162:0] y;
    int lat;
    logic err;
    foreach (av[i]) begin
      op(wv[i], av[i], y, lat, err);
      tests++;
      if (y !== xv[i]) begin
        fails++;
        $display("FAIL vec_c inst=%0d a=%h got %h want %h", wv[i], av[i], y, xv[i]);
      end
      tests++;
      if (lat != lv[i]) begin
        fails++;
        $display("FAIL vec_latency inst=%0d got %0d want %0d", wv[i], lat, lv[i]);
      end
      tests++;
      if (err !== 1'b0) begin
        fails++;
        $display("FAIL vec_chk_err inst=%0d got %b want 0", wv[i], err);
      end
    end
  endtask

  task automatic test_exhaustive_m5;
    int ws[2] = '{1, 3};
    int ls[2] = '{5, 3};
    logic [162:0] b, y;
    int lat;
    logic err;
    foreach (ws[k]) begin
      for (int i = 0; i < 32; i++) begin
        b = 163'(i);
        op(ws[k], mulmod(b, b, 5, 163'h05), y, lat, err);
        tests++;
        if (y !== b || lat != ls[k]) begin
          fails++;
          $display("FAIL m5_sweep inst=%0d got c=%h lat=%0d want c=%h lat=%0d",
                   ws[k], y, lat, b, ls[k]);
        end
      end
    end
  endtask

  task automatic test_random_163;
    logic [191:0] raw;
    logic [162:0] b, y;
    int lat;
    logic err;
    for (int i = 0; i < 1000; i++) begin
      raw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b = raw[162:0];
      op(163, mulmod(b, b, 163, FB), y, lat, err);
      tests++;
      if (y !== b) begin
        fails++;
        $display("FAIL rand_c got %h want %h", y, b);
      end
      tests++;
      if (lat != 25 || err !== 1'b0) begin
        fails++;
        $display("FAIL rand_lat_err got lat=%0d err=%b want lat=25 err=0", lat, err);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [4:0] b2;
    logic [4:0] a2;
    int lat;
    int n;
    b2 = 5'h0A;
    a2 = 5'(mulmod(163'(b2), 163'(b2), 5, 163'h05));
    v1 = 1'b1; a1 = 5'h02;
    @(posedge clk); #1;
    v1 = 1'b0;
    n = 0;
    while (!ov1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (ov1 !== 1'b1) begin
      fails++;
      $display("FAIL bp_first_valid got %b want 1", ov1);
    end
    v1 = 1'b1; a1 = a2;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tests++;
      if (ov1 !== 1'b1 || c1 !== 5'h1B || r1 !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc=%0d got ov=%b c=%h rdy=%b want ov=1 c=1b rdy=0",
                 i, ov1, c1, r1);
      end
    end
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    tests++;
    if (ov1 !== 1'b0 || r1 !== 1'b1) begin
      fails++;
      $display("FAIL bp_release got ov=%b rdy=%b want ov=0 rdy=1", ov1, r1);
    end
    @(posedge clk); #1;
    v1 = 1'b0;
    tests++;
    if (r1 !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept_u1 got rdy=%b want 0", r1);
    end
    lat = 1;
    while (!ov1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (c1 !== b2 || lat != 5) begin
      fails++;
      $display("FAIL bp_second got c=%h lat=%0d want c=%h lat=5", c1, lat, b2);
    end
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
  endtask

  task automatic test_reset_midrun;
    logic [162:0] b, y;
    int lat;
    logic err;
    vb = 1'b1; ab = mulmod(163'h5, 163'h5, 163, FB);
    @(posedge clk); #1;
    vb = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (ovb !== 1'b0 || cb !== '0 || rb !== 1'b1 || eb !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset got ov=%b c=%h rdy=%b err=%b want 0 0 1 0",
               ovb, cb, rb, eb);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (ovb !== 1'b0 || cb !== '0 || rb !== 1'b1) begin
      fails++;
      $display("FAIL midrun_after got ov=%b c=%h rdy=%b want 0 0 1", ovb, cb, rb);
    end
    b = 163'h7_0000_0000_0000_0000_0000_0000_0000_0000_1234_5678;
    op(163, mulmod(b, b, 163, FB), y, lat, err);
    tests++;
    if (y !== b || lat != 25) begin
      fails++;
      $display("FAIL midrun_next got c=%h lat=%0d want c=%h lat=25", y, lat, b);
    end
  endtask

`ifdef GF2M_SQRT_CHECK_EN
  task automatic test_check;
    int n;
    v1 = 1'b1; a1 = 5'h02;
    @(posedge clk); #1;
    v1 = 1'b0;
    @(posedge clk); #1;
    force u1.acc_q = 5'h1F;
    @(posedge clk); #1;
    release u1.acc_q;
    n = 0;
    while (!ov1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (ov1 !== 1'b1 || e1 !== 1'b1) begin
      fails++;
      $display("FAIL check_corrupt got ov=%b err=%b want 1 1", ov1, e1);
    end
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    tests++;
    if (e1 !== 1'b0) begin
      fails++;
      $display("FAIL check_clear got err=%b want 0", e1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_exhaustive_m5();
    test_backpressure();
    test_reset_midrun();
`ifdef GF2M_SQRT_CHECK_EN
    test_check();
`endif
    test_random_163();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
